// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the retire trace buffer.
//   trace_rec_t   - one captured retire record (pc, instr, rd, we, wdata, stamp)
//   trace_mode_e  - capture mode selected at arm time
//   trace_state_e - capture controller states
package trace_pkg;

    localparam int unsigned TRACE_XLEN  = 32;
    localparam int unsigned TRACE_CNT_W = 32;

    typedef struct packed {
        logic [TRACE_XLEN-1:0]  pc;
        logic [31:0]            instr;
        logic [4:0]             rd;
        logic                   we;
        logic [TRACE_XLEN-1:0]  wdata;
        logic [TRACE_CNT_W-1:0] stamp;
    } trace_rec_t;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_STOP = 2'd1,
        MODE_TRIG = 2'd2,
        MODE_RSVD = 2'd3
    } trace_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    // Reserved encoding behaves as wrap mode.
    function automatic trace_mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_WRAP : trace_mode_e'(m);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W storage, one synchronous write port, asynchronous read.
//   clk            clock
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port
// Storage is intentionally not reset.
module trace_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned W     = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: circular capture of retired-instruction records for debug.
//   clk, rst (async, active low)
//   retire_*   retire/writeback record source, one record per retire_valid
//   cfg_*      mode / trigger pc / post-trigger count, latched on arm
//   arm, clear start capture / flush and go idle (clear wins)
//   rd_*       valid/ready drain port presenting the oldest record
//   count, busy, done, triggered, overflow  status
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN  = TRACE_XLEN,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = TRACE_CNT_W,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_instr,
    input  logic [4:0]       retire_rd,
    input  logic             retire_we,
    input  logic [XLEN-1:0]  retire_wdata,
    input  logic [1:0]       cfg_mode,
    input  logic [XLEN-1:0]  cfg_trig_pc,
    input  logic [PW:0]      cfg_post,
    input  logic             arm,
    input  logic             clear,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [XLEN-1:0]  rd_pc,
    output logic [31:0]      rd_instr,
    output logic [4:0]       rd_rd,
    output logic             rd_we,
    output logic [XLEN-1:0]  rd_wdata,
    output logic [CNT_W-1:0] rd_stamp,
    output logic [PW:0]      count,
    output logic             busy,
    output logic             done,
    output logic             triggered,
    output logic             overflow
);

    localparam int unsigned REC_W = $bits(trace_rec_t);

    trace_state_e     state_q, state_d;
    trace_mode_e      mode_q;
    logic [XLEN-1:0]  trig_pc_q;
    logic [PW:0]      post_q;
    logic [PW:0]      post_cnt_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_nxt_c;
    logic [CNT_W-1:0] stamp_q;
    logic             triggered_q, overflow_q;

    logic             capturing_c, full_c, pop_c, push_c, drop_c;
    logic             trig_hit_c, arm_ok_c;
    trace_rec_t       wr_rec_c, rd_rec_c;

    // Handshake and push qualification.
    assign capturing_c = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    assign full_c      = (count_q == (PW+1)'(DEPTH));
    assign pop_c       = (count_q != '0) && rd_ready && !clear;
    assign push_c      = retire_valid && capturing_c && !clear
                         && !((mode_q == MODE_STOP) && full_c);
    // Full push without a pop overwrites the oldest record.
    assign drop_c      = push_c && full_c && !pop_c;
    assign trig_hit_c  = (state_q == ST_CAPTURE) && (mode_q == MODE_TRIG) && retire_valid
                         && !clear && (retire_pc == trig_pc_q);
    assign arm_ok_c    = arm && !clear && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_c = count_q;
        if (push_c && !(pop_c || drop_c)) begin
            count_nxt_c = count_q + (PW+1)'(1);
        end else if (!push_c && pop_c) begin
            count_nxt_c = count_q - (PW+1)'(1);
        end
    end

    // Record assembled from the retire port.
    always_comb begin
        wr_rec_c       = '0;
        wr_rec_c.pc    = TRACE_XLEN'(retire_pc);
        wr_rec_c.instr = retire_instr;
        wr_rec_c.rd    = retire_rd;
        wr_rec_c.we    = retire_we;
        wr_rec_c.wdata = TRACE_XLEN'(retire_wdata);
        wr_rec_c.stamp = TRACE_CNT_W'(stamp_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (trig_hit_c) begin
                    state_d = (post_q == '0) ? ST_DONE : ST_POST;
                end else if ((mode_q == MODE_STOP) && push_c
                             && (count_nxt_c == (PW+1)'(DEPTH))) begin
                    state_d = ST_DONE;
                end
            end
            ST_POST: begin
                if (push_c && ((post_cnt_q + (PW+1)'(1)) == post_q)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (arm) state_d = ST_CAPTURE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    // Pointers, occupancy, stamp, latched config and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= MODE_WRAP;
            trig_pc_q   <= '0;
            post_q      <= '0;
            post_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stamp_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            stamp_q <= stamp_q + CNT_W'(1);
            if (clear) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                post_cnt_q  <= '0;
                triggered_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (arm_ok_c) begin
                    mode_q      <= decode_mode(cfg_mode);
                    trig_pc_q   <= cfg_trig_pc;
                    post_q      <= cfg_post;
                    triggered_q <= 1'b0;
                end
                if (trig_hit_c) triggered_q <= 1'b1;
                if (drop_c)     overflow_q  <= 1'b1;
                if (push_c)            wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop_c || drop_c)   rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_nxt_c;
                // post_cnt counts pushes after the trigger record only.
                if (state_q == ST_CAPTURE) begin
                    post_cnt_q <= '0;
                end else if ((state_q == ST_POST) && push_c) begin
                    post_cnt_q <= post_cnt_q + (PW+1)'(1);
                end
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata (wr_rec_c),
        .raddr (rd_ptr_q),
        .rdata (rd_rec_c)
    );

    // Drain port and status.
    assign rd_valid  = (count_q != '0);
    assign rd_pc     = XLEN'(rd_rec_c.pc);
    assign rd_instr  = rd_rec_c.instr;
    assign rd_rd     = rd_rec_c.rd;
    assign rd_we     = rd_rec_c.we;
    assign rd_wdata  = XLEN'(rd_rec_c.wdata);
    assign rd_stamp  = CNT_W'(rd_rec_c.stamp);
    assign count     = count_q;
    assign busy      = capturing_c;
    assign done      = (state_q == ST_DONE);
    assign triggered = triggered_q;
    assign overflow  = overflow_q;

endmodule
